// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Single-outstanding memory bus arbiter between IF and LS, LS
//            priority with an IF starvation guard; define ARB_TIMEOUT_EN to
//            enable the transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  output logic                if_rsp_err,
  input  logic                ls_req_valid,
  input  logic                ls_req_we,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic                ls_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                core_lock
);

  localparam int c_STRB_W   = DATA_W / 8;
  localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_owner_ls;
  logic [c_STARVE_W-1:0] r_starve_cnt;
  logic                  r_mem_req_valid;
  logic                  r_mem_req_we;
  logic [ADDR_W-1:0]     r_mem_req_addr;
  logic [DATA_W-1:0]     r_mem_req_wdata;
  logic [c_STRB_W-1:0]   r_mem_req_wstrb;
  logic                  r_if_rsp_valid;
  logic [DATA_W-1:0]     r_if_rsp_data;
  logic                  r_ls_rsp_valid;
  logic [DATA_W-1:0]     r_ls_rsp_rdata;
  logic                  r_core_lock;

  logic                  w_idle;
  logic                  w_starved;
  logic                  w_grant_if;
  logic                  w_grant_ls;
  logic                  w_busy;
  logic                  w_complete;
  logic                  w_timeout_fire;
  logic                  w_finish;
  logic [DATA_W-1:0]     w_rsp_data;

  // Ready is a same-cycle handshake, so the grant stays combinational; reset masks it.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_starved  = (r_starve_cnt == c_STARVE_W'(STARVE_MAX));
  assign w_grant_if = w_idle && if_req_valid && (!ls_req_valid || w_starved);
  assign w_grant_ls = w_idle && ls_req_valid && !w_grant_if;

  assign w_busy     = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_complete = (r_state == S_WAIT) && mem_rsp_valid;
  assign w_finish   = w_complete || w_timeout_fire;
  assign w_rsp_data = (w_timeout_fire || r_mem_req_we) ? '0 : mem_rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_owner_ls      <= 1'b0;
      r_starve_cnt    <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_we    <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_mem_req_wstrb <= '0;
      r_if_rsp_valid  <= 1'b0;
      r_if_rsp_data   <= '0;
      r_ls_rsp_valid  <= 1'b0;
      r_ls_rsp_rdata  <= '0;
      r_core_lock     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_if || w_grant_ls) begin
            r_owner_ls      <= w_grant_ls;
            r_mem_req_valid <= 1'b1;
            r_mem_req_we    <= w_grant_ls && ls_req_we;
            r_mem_req_addr  <= w_grant_ls ? ls_req_addr : if_req_addr;
            r_mem_req_wdata <= w_grant_ls ? ls_req_wdata : '0;
            r_mem_req_wstrb <= w_grant_ls ? ls_req_wstrb : '0;
            r_core_lock     <= w_grant_ls;
            r_state         <= S_REQ;
            if (w_grant_ls && if_req_valid) begin
              r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 1'b1;
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (w_finish) begin
            r_mem_req_valid <= 1'b0;
            r_core_lock     <= 1'b0;
            r_state         <= S_RESP;
            if (r_owner_ls) begin
              r_ls_rsp_valid <= 1'b1;
              r_ls_rsp_rdata <= w_rsp_data;
            end else begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_data  <= w_rsp_data;
            end
          end else if ((r_state == S_REQ) && mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_WAIT;
          end
        end
        S_RESP: begin
          r_if_rsp_valid <= 1'b0;
          r_ls_rsp_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_if_rsp_err;
  logic              r_ls_rsp_err;

  // Fires on the last busy cycle so the response lands TIMEOUT_CYC cycles after REQ entry.
  assign w_timeout_fire = w_busy && !w_complete && (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt     <= '0;
      r_if_rsp_err <= 1'b0;
      r_ls_rsp_err <= 1'b0;
    end else begin
      r_to_cnt <= w_busy ? r_to_cnt + 1'b1 : '0;
      if (w_finish) begin
        r_if_rsp_err <= !r_owner_ls && w_timeout_fire;
        r_ls_rsp_err <= r_owner_ls && w_timeout_fire;
      end else if (r_state == S_RESP) begin
        r_if_rsp_err <= 1'b0;
        r_ls_rsp_err <= 1'b0;
      end
    end
  end

  assign if_rsp_err = r_if_rsp_err;
  assign ls_rsp_err = r_ls_rsp_err;
`else
  assign w_timeout_fire = 1'b0;
  assign if_rsp_err     = 1'b0;
  assign ls_rsp_err     = 1'b0;
`endif

  assign if_req_ready  = w_grant_if;
  assign ls_req_ready  = w_grant_ls;
  assign if_rsp_valid  = r_if_rsp_valid;
  assign if_rsp_data   = r_if_rsp_data;
  assign ls_rsp_valid  = r_ls_rsp_valid;
  assign ls_rsp_rdata  = r_ls_rsp_rdata;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_we    = r_mem_req_we;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_wdata = r_mem_req_wdata;
  assign mem_req_wstrb = r_mem_req_wstrb;
  assign core_lock     = r_core_lock;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Scoreboard bench for mem_bus_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        if_rsp_err;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [63:0] ls_req_addr;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wstrb;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_rdata;
  logic        ls_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        core_lock;

  typedef struct packed {
    logic        is_ls;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mem_auto = 1'b1;
  int          ready_delay = 0;
  int          rsp_delay = 0;
  bit          man_ready = 1'b0;
  bit          man_rsp = 1'b0;
  logic [63:0] man_data = '0;
  bit          expect_timeout = 1'b0;

  mem_bus_arbiter #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .STARVE_MAX (4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .ls_req_valid (ls_req_valid),
    .ls_req_we    (ls_req_we),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_wstrb (ls_req_wstrb),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_rdata (ls_rsp_rdata),
    .ls_rsp_err   (ls_rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we   (mem_req_we),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .core_lock    (core_lock)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013;
    return {a[31:0] ^ 32'hA5A5_5A5A, a[31:0] ^ 32'h0F0F_F0F0};
  endfunction

  // Memory: auto mode accepts after ready_delay cycles and answers rsp_delay cycles later.
  task automatic mem_loop();
    int          rdy_cnt  = 0;
    int          rsp_wait = 0;
    bit          pending  = 1'b0;
    logic [63:0] pdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (pending) begin
          if (rsp_wait == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = pdata;
            pending       = 1'b0;
          end else begin
            rsp_wait--;
          end
        end else if (mem_req_valid) begin
          if (rdy_cnt >= ready_delay) begin
            mem_req_ready = 1'b1;
            pending       = 1'b1;
            pdata         = mem_model(mem_req_addr);
            rsp_wait      = rsp_delay;
            rdy_cnt       = 0;
          end else begin
            rdy_cnt++;
          end
        end else begin
          rdy_cnt = 0;
        end
      end else begin
        mem_req_ready = man_ready;
        mem_rsp_valid = man_rsp;
        mem_rsp_rdata = man_data;
        pending       = 1'b0;
        rdy_cnt       = 0;
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (if_req_ready === 1'b1) begin
        e.is_ls = 1'b0; e.data = mem_model(if_req_addr); e.err = 1'b0;
        sb.push_back(e);
      end
      if (ls_req_ready === 1'b1) begin
        e.is_ls = 1'b1;
        e.data  = (expect_timeout || ls_req_we) ? 64'h0 : mem_model(ls_req_addr);
        e.err   = expect_timeout;
        sb.push_back(e);
      end
      if (if_rsp_valid === 1'b1 || ls_rsp_valid === 1'b1) begin
        got.is_ls = ls_rsp_valid;
        got.data  = ls_rsp_valid ? ls_rsp_rdata : if_rsp_data;
        got.err   = ls_rsp_valid ? ls_rsp_err : if_rsp_err;
        n_checks++;
        if (if_rsp_valid === 1'b1 && ls_rsp_valid === 1'b1) begin
          n_errors++;
          $display("FAIL sb_dual_rsp: both if_rsp_valid and ls_rsp_valid high, required one");
        end else if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected_rsp: got %h, required no response", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            n_errors++;
            $display("FAIL sb_rsp: got %h, required %h", got, e);
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((sb.size() != 0 || mem_req_valid || core_lock) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    if_req_valid = 1'b1; if_req_addr  = 64'h10;
    ls_req_valid = 1'b1; ls_req_we    = 1'b1; ls_req_addr = 64'h20;
    ls_req_wdata = 64'hFFFF; ls_req_wstrb = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({if_req_ready, ls_req_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_ready: got %b, required 00", {if_req_ready, ls_req_ready});
    end
    n_checks++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb} !== '0) begin
      n_errors++;
      $display("FAIL reset_mem_req: got v=%b a=%h d=%h, required all 0",
               mem_req_valid, mem_req_addr, mem_req_wdata);
    end
    n_checks++;
    if ({if_rsp_valid, if_rsp_data, if_rsp_err, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_rsp: got if=%h ls=%h, required all 0", if_rsp_data, ls_rsp_rdata);
    end
    n_checks++;
    if (core_lock !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_core_lock: got %b, required 0", core_lock);
    end
    @(posedge clk); #1;
    rst = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_we = 1'b0;
    ls_req_wdata = '0; ls_req_wstrb = '0;
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, core_lock, if_req_ready, ls_req_ready} !== 4'b0000) begin
      n_errors++;
      $display("FAIL post_reset_idle: got %b, required 0000",
               {mem_req_valid, core_lock, if_req_ready, ls_req_ready});
    end
  endtask

  task automatic test_if_read();
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    @(negedge clk);
    n_checks++;
    if ({if_req_ready, ls_req_ready, core_lock} !== 3'b100) begin
      n_errors++;
      $display("FAIL if_accept: got rdy/lsrdy/lock=%b, required 100",
               {if_req_ready, ls_req_ready, core_lock});
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0; if_req_addr = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (core_lock !== 1'b0) begin
        n_errors++;
        $display("FAIL if_core_lock T+%0d: got %b, required 0", k, core_lock);
      end
      if (k == 1) begin
        n_checks++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb} !== {1'b1, 1'b0, 64'h8000_0000, 8'h00}) begin
          n_errors++;
          $display("FAIL if_mem_req: got v=%b we=%b a=%h s=%h, required 1 0 80000000 00",
                   mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb);
        end
      end else if (k == 3) begin
        n_checks++;
        if ({if_rsp_valid, if_rsp_data, if_rsp_err} !== {1'b1, 64'h13, 1'b0}) begin
          n_errors++;
          $display("FAIL if_rsp_T+3: got v=%b d=%h e=%b, required 1 13 0",
                   if_rsp_valid, if_rsp_data, if_rsp_err);
        end
      end else begin
        n_checks++;
        if ({mem_req_valid, if_rsp_valid} !== 2'b00) begin
          n_errors++;
          $display("FAIL if_quiet T+%0d: got req/rsp=%b, required 00", k, {mem_req_valid, if_rsp_valid});
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_ls_write();
    ready_delay = 3;
    @(posedge clk); #1;
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 64'h1000;
    ls_req_wdata = 64'hDEAD_BEEF; ls_req_wstrb = 8'h0F;
    @(negedge clk);
    n_checks++;
    if ({ls_req_ready, if_req_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL ls_accept: got ls/if rdy=%b, required 10", {ls_req_ready, if_req_ready});
    end
    @(posedge clk); #1;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wstrb = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (k <= 4) begin
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb, core_lock}
            !== {1'b1, 1'b1, 64'h1000, 64'hDEAD_BEEF, 8'h0F, 1'b1}) begin
          n_errors++;
          $display("FAIL ls_req_stable T+%0d: got v=%b we=%b a=%h d=%h s=%h lock=%b, required 1 1 1000 deadbeef 0f 1",
                   k, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb, core_lock);
        end
      end else if (k == 5) begin
        if ({mem_req_valid, core_lock, ls_rsp_valid} !== 3'b010) begin
          n_errors++;
          $display("FAIL ls_wait: got req/lock/rsp=%b, required 010", {mem_req_valid, core_lock, ls_rsp_valid});
        end
      end else if (k == 6) begin
        if ({ls_rsp_valid, ls_rsp_rdata, core_lock} !== {1'b1, 64'h0, 1'b0}) begin
          n_errors++;
          $display("FAIL ls_rsp: got v=%b d=%h lock=%b, required 1 0 0", ls_rsp_valid, ls_rsp_rdata, core_lock);
        end
      end else begin
        if (ls_rsp_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL ls_rsp_pulse: got %b after one cycle, required 0", ls_rsp_valid);
        end
      end
    end
    ready_delay = 0;
    wait_drain();
  endtask

  task automatic test_starvation();
    logic [9:0] got_seq = '0;
    logic [9:0] exp_seq = 10'b10_0001_0000;
    int         grants  = 0;
    int         last    = 0;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h2000;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'h3000;
    for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
      @(negedge clk);
      if (if_req_ready === 1'b1 && ls_req_ready === 1'b1) begin
        n_checks++; n_errors++;
        $display("FAIL starve_dual_grant: both readies high at cycle %0d, required one", cyc);
      end else if (if_req_ready === 1'b1 || ls_req_ready === 1'b1) begin
        got_seq[grants] = if_req_ready;
        if (grants > 0) begin
          n_checks++;
          if (cyc - last != 4) begin
            n_errors++;
            $display("FAIL starve_gap grant %0d: got %0d cycles, required 4", grants, cyc - last);
          end
        end
        last = cyc;
        grants++;
      end
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    n_checks++;
    if (grants != 10 || got_seq !== exp_seq) begin
      n_errors++;
      $display("FAIL starve_sequence: got %0d grants seq %b, required 10 grants seq %b (1=IF)",
               grants, got_seq, exp_seq);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    rsp_delay = 2;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0040;
    @(negedge clk);
    n_checks++;
    if (if_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_accept: got %b, required 1", if_req_ready);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, if_rsp_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_wait: got req/rsp=%b, required 00", {mem_req_valid, if_rsp_valid});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, mem_req_addr, if_rsp_valid, if_rsp_data, ls_rsp_valid, ls_rsp_rdata, core_lock} !== '0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got a=%h ifd=%h lsd=%h, required all 0",
               mem_req_addr, if_rsp_data, ls_rsp_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({if_rsp_valid, ls_rsp_valid, mem_req_valid} !== 3'b000) begin
        n_errors++;
        $display("FAIL rstmid_late_rsp %0d: got if/ls/req=%b, required 000",
                 k, {if_rsp_valid, ls_rsp_valid, mem_req_valid});
      end
    end
    rsp_delay = 0;
    test_if_read();
  endtask

  task automatic test_ignore_rsp();
    mem_auto = 1'b0; man_ready = 1'b0; man_rsp = 1'b0;
    @(negedge clk);
    man_rsp = 1'b1; man_data = 64'hBAD0_BAD0;
    @(negedge clk);
    man_rsp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({if_rsp_valid, ls_rsp_valid, mem_req_valid} !== 3'b000) begin
        n_errors++;
        $display("FAIL idle_rsp_ignored %0d: got if/ls/req=%b, required 000",
                 k, {if_rsp_valid, ls_rsp_valid, mem_req_valid});
      end
    end
    @(posedge clk); #1;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'h4000;
    @(negedge clk);
    n_checks++;
    if (ls_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ign_accept: got %b, required 1", ls_req_ready);
    end
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    @(negedge clk);
    man_rsp = 1'b1; man_data = 64'h1111_1111;
    @(negedge clk);
    man_rsp = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, core_lock, ls_rsp_valid, mem_req_addr} !== {1'b1, 1'b1, 1'b0, 64'h4000}) begin
      n_errors++;
      $display("FAIL req_rsp_ignored: got v=%b lock=%b rsp=%b a=%h, required 1 1 0 4000",
               mem_req_valid, core_lock, ls_rsp_valid, mem_req_addr);
    end
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, core_lock} !== 2'b01) begin
      n_errors++;
      $display("FAIL ign_wait: got req/lock=%b, required 01", {mem_req_valid, core_lock});
    end
    man_rsp = 1'b1; man_data = mem_model(64'h4000);
    @(negedge clk);
    man_rsp = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ls_rsp_valid, ls_rsp_rdata, core_lock} !== {1'b1, mem_model(64'h4000), 1'b0}) begin
      n_errors++;
      $display("FAIL ign_rsp: got v=%b d=%h lock=%b, required 1 %h 0",
               ls_rsp_valid, ls_rsp_rdata, core_lock, mem_model(64'h4000));
    end
    mem_auto = 1'b1;
    wait_drain();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    mem_auto = 1'b0; man_rsp = 1'b0; man_ready = 1'b1; expect_timeout = 1'b1;
    @(posedge clk); #1;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'h5000;
    @(negedge clk);
    n_checks++;
    if (ls_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL to_accept: got %b, required 1", ls_req_ready);
    end
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < 9) begin
        if ({core_lock, ls_rsp_valid} !== 2'b10) begin
          n_errors++;
          $display("FAIL to_busy T+%0d: got lock/rsp=%b, required 10", k, {core_lock, ls_rsp_valid});
        end
      end else if ({ls_rsp_valid, ls_rsp_err, ls_rsp_rdata, core_lock} !== {1'b1, 1'b1, 64'h0, 1'b0}) begin
        n_errors++;
        $display("FAIL to_rsp: got v=%b e=%b d=%h lock=%b, required 1 1 0 0",
                 ls_rsp_valid, ls_rsp_err, ls_rsp_rdata, core_lock);
      end
    end
    expect_timeout = 1'b0; man_ready = 1'b0; mem_auto = 1'b1;
    wait_drain();
  endtask
`endif

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0;
    ls_req_wdata = '0; ls_req_wstrb = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    fork
      mem_loop();
      monitor_loop();
      watchdog();
    join_none
    test_reset();
    test_if_read();
    test_ls_write();
    test_starvation();
    test_reset_mid();
    test_ignore_rsp();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
